// File: rtl/ternary_popcount_neuron_if.sv
// Beat-input and result-output stream bundle for ternary_popcount_neuron.
// The master drives beats and consumes results; the slave is the neuron.
interface ternary_popcount_neuron_if #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned BEATS = 4
);
  localparam int unsigned ACC_W = $clog2(WIDTH * BEATS + 1) + 1;

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_pos;
  logic [WIDTH-1:0]        in_neg;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] out_sum;
  logic [1:0]              out_trit;

  modport master (
    output in_valid,
    output in_pos,
    output in_neg,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  out_trit
  );

  modport slave (
    input  in_valid,
    input  in_pos,
    input  in_neg,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output out_trit
  );
endinterface

// File: rtl/ternary_popcount_neuron.sv
// Streaming ternary neuron: accumulates popcount(pos) - popcount(neg) over BEATS
// beats, then thresholds the signed sum into a +1 / 0 / -1 decision.
module ternary_popcount_neuron #(
  parameter  int unsigned WIDTH = 10,
  parameter  int unsigned BEATS = 4,
  localparam int unsigned ACC_W = $clog2(WIDTH * BEATS + 1) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ternary_popcount_neuron_if.slave bus,
  input  logic signed [ACC_W-1:0] thresh_hi,
  input  logic signed [ACC_W-1:0] thresh_lo,
  output logic                    busy
);
  localparam int unsigned PC_W  = $clog2(WIDTH + 1);
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;
  localparam logic [1:0] TRIT_ZERO = 2'b00;

  typedef enum logic [1:0] {
    ACC  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    in_ready_q;
  logic [CNT_W-1:0]        beat_cnt_q;
  logic [CNT_W-1:0]        beat_cnt_d;
  logic                    busy_q;
  logic                    busy_d;

  logic                    s1_valid_q;
  logic                    s1_last_q;
  logic signed [ACC_W-1:0] s1_d_q;
  logic signed [ACC_W-1:0] acc_q;

  logic                    out_valid_q;
  logic signed [ACC_W-1:0] out_sum_q;
  logic [1:0]              out_trit_q;

  logic                    accept_c;
  logic                    handshake_c;
  logic                    last_beat_c;
  logic [PC_W-1:0]         pc_pos_c;
  logic [PC_W-1:0]         pc_neg_c;
  logic signed [ACC_W-1:0] d_c;
  logic signed [ACC_W-1:0] sum_c;
  logic [1:0]              trit_c;

  function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] mask);
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n = n + PC_W'(mask[i]);
    end
    return n;
  endfunction

  assign accept_c    = bus.in_valid && in_ready_q;
  assign handshake_c = out_valid_q && bus.out_ready;
  assign last_beat_c = (beat_cnt_q == LAST_BEAT);

  // Per-beat net contribution; overlapping pos/neg bits cancel naturally.
  assign pc_pos_c = popcount(bus.in_pos);
  assign pc_neg_c = popcount(bus.in_neg);
  assign d_c      = $signed(ACC_W'(pc_pos_c)) - $signed(ACC_W'(pc_neg_c));

  assign sum_c = acc_q + s1_d_q;

  // Upper threshold takes priority when the two ranges overlap.
  always_comb begin
    trit_c = TRIT_ZERO;
    if (sum_c >= thresh_hi) begin
      trit_c = TRIT_POS;
    end else if (sum_c <= thresh_lo) begin
      trit_c = TRIT_NEG;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (accept_c) begin
      beat_cnt_d = last_beat_c ? '0 : beat_cnt_q + CNT_W'(1);
    end
    case (state_q)
      ACC:     if (accept_c && last_beat_c) state_d = WAIT;
      WAIT:    state_d = HOLD;
      HOLD:    if (handshake_c) state_d = ACC;
      default: state_d = ACC;
    endcase
    busy_d = (beat_cnt_d != '0) || (state_d != ACC) || accept_c;
  end

  // in_ready and busy are registered copies of next-cycle control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC;
      in_ready_q <= 1'b0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == ACC);
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_d_q     <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_d_q    <= d_c;
        s1_last_q <= last_beat_c;
      end
    end
  end

  // Stage 2: fold the registered beat into the sum; the final beat publishes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_trit_q  <= TRIT_ZERO;
    end else begin
      if (s1_valid_q) begin
        if (s1_last_q) begin
          out_sum_q  <= sum_c;
          out_trit_q <= trit_c;
          acc_q      <= '0;
        end else begin
          acc_q <= sum_c;
        end
      end
      if (s1_valid_q && s1_last_q) begin
        out_valid_q <= 1'b1;
      end else if (handshake_c) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_trit  = out_trit_q;
  assign busy          = busy_q;

endmodule
